// File: rtl/sound_mailbox_pkg.sv
// sound_mailbox_pkg
//   Shared constants for the sound mailbox: default parameter values,
//   STATUS bit positions, STATUS reset value and the strobe-sample record.
`timescale 1ns/1ps
package sound_mailbox_pkg;

   localparam int DEF_DATA_W    = 8;
   localparam int DEF_CMD_DEPTH = 4;
   localparam int DEF_REP_DEPTH = 4;
   localparam int DEF_NMI_LEN   = 8;

   // STATUS = {rep_ovf, cmd_ovf, rep_full, rep_empty, cmd_full, cmd_empty}
   localparam int ST_CMD_EMPTY = 0;
   localparam int ST_CMD_FULL  = 1;
   localparam int ST_REP_EMPTY = 2;
   localparam int ST_REP_FULL  = 3;
   localparam int ST_CMD_OVF   = 4;
   localparam int ST_REP_OVF   = 5;
   localparam int ST_W         = 6;

   // Both FIFOs empty, nothing full, both overflow flags cleared.
   localparam logic [ST_W-1:0] STATUS_RST = 6'b000101;

   // Previous-cycle samples of the active-low strobes.
   typedef struct packed {
      logic zone;    // nICOM_ZONE
      logic z80r;    // nSDZ80R
      logic z80w;    // nSDZ80W
      logic z80clr;  // nSDZ80CLR
   } strobe_t;

   localparam strobe_t STROBE_IDLE = '{zone: 1'b1, z80r: 1'b1, z80w: 1'b1, z80clr: 1'b1};

endpackage

// File: rtl/sound_mailbox_fifo.sv
// mbox_fifo
//   Small circular FIFO with combinational head visibility.
//   Ports:
//     clk, rst_n          clock, asynchronous active-low reset
//     push_i, din_i       write request and data
//     pop_i               read request (ignored when empty)
//     flush_i             empties the FIFO; overrides push and pop
//     dout_o              head entry, zero when empty
//     full_o, empty_o     occupancy flags
//     count_o             occupancy, 0..DEPTH
//     push_ok_o           push accepted this cycle
//     drop_o              push rejected because the FIFO was full
`timescale 1ns/1ps
module mbox_fifo
   import sound_mailbox_pkg::*;
#(
   parameter int WIDTH = DEF_DATA_W,
   parameter int DEPTH = DEF_CMD_DEPTH
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       push_i,
   input  logic                       pop_i,
   input  logic                       flush_i,
   input  logic [WIDTH-1:0]           din_i,
   output logic [WIDTH-1:0]           dout_o,
   output logic                       full_o,
   output logic                       empty_o,
   output logic [$clog2(DEPTH):0]     count_o,
   output logic                       push_ok_o,
   output logic                       drop_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             do_push, do_pop;

   assign full_o  = (count_q == CW'(DEPTH));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign dout_o  = empty_o ? '0 : mem_q[rd_ptr_q];

   // A full FIFO still accepts a push when the head leaves in the same cycle.
   assign do_pop    = pop_i & ~empty_o & ~flush_i;
   assign do_push   = push_i & (~full_o | pop_i) & ~flush_i;
   assign push_ok_o = do_push;
   assign drop_o    = push_i & full_o & ~pop_i & ~flush_i;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         // Power-of-two depth: pointers wrap by natural overflow.
         if (do_push) wr_ptr_d = AW'(wr_ptr_q + 1'b1);
         if (do_pop)  rd_ptr_d = AW'(rd_ptr_q + 1'b1);
         case ({do_push, do_pop})
            2'b10:   count_d = CW'(count_q + 1'b1);
            2'b01:   count_d = CW'(count_q - 1'b1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: dout_o is masked whenever the FIFO is empty.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= din_i;
   end

endmodule

// File: rtl/sound_mailbox.sv
// sound_mailbox
//   68K <-> Z80 sound-CPU mailbox: a command FIFO written by the 68K and
//   read by the Z80, and a reply FIFO written by the Z80 and read by the 68K.
//   Ports:
//     CLK_24M, nRESET        clock, asynchronous active-low reset
//     nICOM_ZONE, RW         68K register select (low) and read/write (1=read)
//     M68K_DIN / M68K_DOUT   68K command data in / reply head out
//     M68K_OE                68K read enable (combinational)
//     nSDZ80R / nSDZ80W      Z80 command read / reply write strobes (low)
//     nSDZ80CLR              Z80 command-FIFO clear (falling edge)
//     SDD_IN / SDD_OUT       Z80 reply data in / command head out
//     SDD_OE                 Z80 read enable (combinational)
//     nSDW                   low pulse of NMI_LEN clocks per accepted command
//     STATUS                 {rep_ovf, cmd_ovf, rep_full, rep_empty, cmd_full, cmd_empty}
`timescale 1ns/1ps
module sound_mailbox
   import sound_mailbox_pkg::*;
#(
   parameter int DATA_W    = DEF_DATA_W,
   parameter int CMD_DEPTH = DEF_CMD_DEPTH,
   parameter int REP_DEPTH = DEF_REP_DEPTH,
   parameter int NMI_LEN   = DEF_NMI_LEN
) (
   input  logic              CLK_24M,
   input  logic              nRESET,
   input  logic              nICOM_ZONE,
   input  logic              RW,
   input  logic [DATA_W-1:0] M68K_DIN,
   output logic [DATA_W-1:0] M68K_DOUT,
   output logic              M68K_OE,
   input  logic              nSDZ80R,
   input  logic              nSDZ80W,
   input  logic              nSDZ80CLR,
   input  logic [DATA_W-1:0] SDD_IN,
   output logic [DATA_W-1:0] SDD_OUT,
   output logic              SDD_OE,
   output logic              nSDW,
   output logic [ST_W-1:0]   STATUS
);

   localparam int NW = $clog2(NMI_LEN + 1);

   strobe_t          strobe_now, strobe_q;
   logic             rw_q;
   logic [DATA_W-1:0] sdd_q;
   logic             armed_q;

   logic             zone_fall, zone_rise, z80r_rise, z80w_rise, clr_fall;
   logic             cmd_push, cmd_pop, cmd_flush, rep_push, rep_pop;
   logic             cmd_full, cmd_empty, cmd_push_ok, cmd_drop;
   logic             rep_full, rep_empty, rep_push_ok, rep_drop;
   logic [$clog2(CMD_DEPTH):0] cmd_count;
   logic [$clog2(REP_DEPTH):0] rep_count;
   logic             cmd_ovf_q, cmd_ovf_d;
   logic             rep_ovf_q, rep_ovf_d;
   logic [NW-1:0]    nmi_cnt_q, nmi_cnt_d;

   assign strobe_now = {nICOM_ZONE, nSDZ80R, nSDZ80W, nSDZ80CLR};

   // Strobe history. RW and SDD_IN are also kept one cycle so that end-of-
   // access events use the values seen while the strobe was still low.
   // armed_q masks the first cycle after reset release so that inputs held
   // low across reset cannot produce a falling-edge event.
   always_ff @(posedge CLK_24M or negedge nRESET) begin
      if (!nRESET) begin
         strobe_q <= STROBE_IDLE;
         rw_q     <= 1'b0;
         sdd_q    <= '0;
         armed_q  <= 1'b0;
      end else begin
         strobe_q <= strobe_now;
         rw_q     <= RW;
         sdd_q    <= SDD_IN;
         armed_q  <= 1'b1;
      end
   end

   assign zone_fall = armed_q &  strobe_q.zone   & ~strobe_now.zone;
   assign zone_rise = armed_q & ~strobe_q.zone   &  strobe_now.zone;
   assign z80r_rise = armed_q & ~strobe_q.z80r   &  strobe_now.z80r;
   assign z80w_rise = armed_q & ~strobe_q.z80w   &  strobe_now.z80w;
   assign clr_fall  = armed_q &  strobe_q.z80clr & ~strobe_now.z80clr;

   assign cmd_push  = zone_fall & ~RW;
   assign cmd_pop   = z80r_rise;
   assign cmd_flush = clr_fall;      // flush overrides a coincident push
   assign rep_push  = z80w_rise;
   assign rep_pop   = zone_rise & rw_q;

   mbox_fifo #(.WIDTH(DATA_W), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
      .clk       (CLK_24M),
      .rst_n     (nRESET),
      .push_i    (cmd_push),
      .pop_i     (cmd_pop),
      .flush_i   (cmd_flush),
      .din_i     (M68K_DIN),
      .dout_o    (SDD_OUT),
      .full_o    (cmd_full),
      .empty_o   (cmd_empty),
      .count_o   (cmd_count),
      .push_ok_o (cmd_push_ok),
      .drop_o    (cmd_drop)
   );

   mbox_fifo #(.WIDTH(DATA_W), .DEPTH(REP_DEPTH)) u_rep_fifo (
      .clk       (CLK_24M),
      .rst_n     (nRESET),
      .push_i    (rep_push),
      .pop_i     (rep_pop),
      .flush_i   (1'b0),
      .din_i     (sdd_q),
      .dout_o    (M68K_DOUT),
      .full_o    (rep_full),
      .empty_o   (rep_empty),
      .count_o   (rep_count),
      .push_ok_o (rep_push_ok),
      .drop_o    (rep_drop)
   );

   // Occupancy counts and the reply accept strobe are not needed here.
   logic unused_ok;
   assign unused_ok = ^{cmd_count, rep_count, rep_push_ok};

   always_comb begin
      cmd_ovf_d = cmd_ovf_q;
      rep_ovf_d = rep_ovf_q;
      nmi_cnt_d = nmi_cnt_q;
      if (cmd_flush)     cmd_ovf_d = 1'b0;
      else if (cmd_drop) cmd_ovf_d = 1'b1;
      if (rep_drop)      rep_ovf_d = 1'b1;
      // Every accepted command restarts the NMI pulse.
      if (cmd_push_ok)          nmi_cnt_d = NW'(NMI_LEN);
      else if (nmi_cnt_q != '0) nmi_cnt_d = NW'(nmi_cnt_q - 1'b1);
   end

   always_ff @(posedge CLK_24M or negedge nRESET) begin
      if (!nRESET) begin
         cmd_ovf_q <= 1'b0;
         rep_ovf_q <= 1'b0;
         nmi_cnt_q <= '0;
      end else begin
         cmd_ovf_q <= cmd_ovf_d;
         rep_ovf_q <= rep_ovf_d;
         nmi_cnt_q <= nmi_cnt_d;
      end
   end

   assign nSDW    = (nmi_cnt_q == '0);
   assign M68K_OE = RW & ~nICOM_ZONE;
   assign SDD_OE  = ~nSDZ80R;

   always_comb begin
      STATUS               = '0;
      STATUS[ST_CMD_EMPTY] = cmd_empty;
      STATUS[ST_CMD_FULL]  = cmd_full;
      STATUS[ST_REP_EMPTY] = rep_empty;
      STATUS[ST_REP_FULL]  = rep_full;
      STATUS[ST_CMD_OVF]   = cmd_ovf_q;
      STATUS[ST_REP_OVF]   = rep_ovf_q;
   end

endmodule
